anton_neopixel_bus_arbiter: RTL and testbench
=============================================

# anton_neopixel_bus_arbiter

Two-master arbiter and sequencer for the NeoPixel controller's byte-wide register/pixel bus. It sits between the CPU bridge (master 0) and the animation engine (master 1) on one side and the controller's `busAddr`/`busDataIn`/`busWrite`/`busRead`/`busDataOut` port on the other. It grants masters round-robin, honours short lock bursts, and optionally defers pixel-buffer writes until the strip is in its reset/latch window, so a frame never tears mid-transmit.

## Interface
- `ADDR_BITS`, 14: bus address width; bit `ADDR_BITS-1` = 0 selects pixel buffer, 1 selects registers.
- `HOLD_MAX`, 16: maximum consecutive grants to a locking owner while the other master waits (≥1).
- `SYNC_STAGES`, 2: flops in the `neoState` synchronizer (≥2).

- `busClk` in 1: single clock for all logic.
- `busResetN` in 1: reset, asynchronous assert, active-low.
- `m0Req`, `m1Req` in 1: access request; held with its command until the matching ack.
- `m0Write`, `m1Write` in 1: 1 = write, 0 = read.
- `m0Addr`, `m1Addr` in ADDR_BITS: target address.
- `m0Data`, `m1Data` in 8: write data.
- `m0Lock`, `m1Lock` in 1: request to keep the grant for the next access.
- `m0Ack`, `m1Ack` out 1: one-cycle pulse; the command was issued on the bus this cycle.
- `m0RValid`, `m1RValid` out 1: one-cycle pulse; read data is valid on `rData`.
- `rData` out 8: registered read data, shared by both masters.
- `tearFreeEn` in 1: enables deferral of buffer writes.
- `neoState` in 1: controller state (0 = transmit, 1 = reset window). Asynchronous to `busClk`.
- `busAddr` out ADDR_BITS; `busDataIn` out 8; `busWrite` out 1; `busRead` out 1: registered controller bus.
- `busDataOut` in 8: controller read data. Valid the cycle after the `busRead` strobe.
- `owner` out 1: master holding or last holding the grant.
- `deferred` out 1: high while a buffer write waits for the reset window.

## Operation
- States: IDLE, ISSUE, RDWAIT, RDRET, DEFER.
- **IDLE**: arbitrate among asserted requests and latch the winner's command.
  - Go to DEFER if the command is a write, the address MSB is 0, `tearFreeEn`=1 and synced `neoState`=0.
  - Otherwise go to ISSUE.
  - Stay in IDLE if there are no requests.
- **ISSUE**: drive the bus strobe and the winner's ack for exactly one cycle.
  - Write: next state IDLE.
  - Read: next state RDWAIT.
- **RDWAIT**: capture `busDataOut` into `rData`; next state RDRET.
- **RDRET**: pulse the owner's RValid; next state IDLE.
- **DEFER**: no strobe; `deferred`=1. Go to ISSUE on the first cycle synced `neoState`=1.
  - Dropping `tearFreeEn` also releases to ISSUE.
  - The other master is not served while in DEFER.
- **Arbitration**:
  - Single requester wins.
  - Both requesting, no lock: the master not granted last wins. `lastGrant` resets to 1, so m0 wins the first tie.
  - The owner keeps the grant while it asserts Lock with Req. `holdCnt` counts consecutive grants to the owner.
  - When `holdCnt`=HOLD_MAX and the other master is requesting, the other master gets the grant and `holdCnt` clears.
  - Lock from a non-owner has no effect until that master is granted.
- Commands are latched only in IDLE. If a requester drops Req after being latched, the access still completes (protocol violation, no abort).
- Read accesses and register-space accesses are never deferred.
- `neoState` passes through a SYNC_STAGES flop chain with reset value 0.

## Timing
- Reset (async, `busResetN`=0) forces:
  - All strobes, acks, RValids and `deferred` to 0.
  - `busAddr`, `busDataIn`, `rData` to 0; `owner` to 0.
  - State to IDLE, `holdCnt` to 0, synchronizer to 0.
  - An in-flight strobe drops immediately with no ack.
- Write, Req first seen at cycle N: strobe and Ack at N+1. The next arbitration is at N+2, giving one write per 2 cycles.
- Read, Req at N: `busRead` and Ack at N+1; `rData` loaded at the end of N+2; RValid at N+3. Throughput is one read per 4 cycles.
- Deferred write: strobe occurs 1 cycle after synced `neoState` rises, i.e. SYNC_STAGES+1 cycles after the raw rise.
- `busAddr`/`busDataIn` hold their last values between strobes.

## Test plan
- **Single write**: m0 writes addr 0x0005 data 0xA5, `tearFreeEn`=0 → `busWrite`=1 with addr 0x0005 and data 0xA5 for exactly 1 cycle; `m0Ack` in the same cycle; `owner`=0.
- **Contention**: m0 and m1 request continuously without lock → grants alternate m0, m1, m0, m1; each ack is 2 cycles after the previous one.
- **Lock starvation bound**: m1 locked and requesting, m0 requesting, HOLD_MAX=4 → after the lock is established, m1 gets 4 consecutive grants, then one m0 grant, then m1 resumes.
- **Read path**: m1 reads 0x2003 while the bus model returns 0x01 → `busRead` at N+1; `rData`=0x01 with `m1RValid` at N+3; `m0RValid` stays 0.
- **Tear-free**: `tearFreeEn`=1, `neoState`=0, m0 writes 0x0002 → `deferred`=1 and no strobe for 50 cycles. Raise `neoState` → `busWrite` SYNC_STAGES+1 cycles later and `deferred` falls. A register write to 0x2002 under the same conditions issues immediately.
- **Reset mid-read**: assert `busResetN`=0 in RDWAIT → all outputs 0 asynchronously and no RValid. After release, the first tie goes to m0.

Source files
------------

// File: rtl/anton_neopixel_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the NeoPixel controller bus.
// Optionally holds pixel-buffer writes until the strip is in its reset window.
module anton_neopixel_bus_arbiter #(
   parameter int unsigned ADDR_BITS   = 14,
   parameter int unsigned HOLD_MAX    = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 busClk,
   input  logic                 busResetN,
   input  logic                 m0Req,
   input  logic                 m0Write,
   input  logic [ADDR_BITS-1:0] m0Addr,
   input  logic [7:0]           m0Data,
   input  logic                 m0Lock,
   output logic                 m0Ack,
   output logic                 m0RValid,
   input  logic                 m1Req,
   input  logic                 m1Write,
   input  logic [ADDR_BITS-1:0] m1Addr,
   input  logic [7:0]           m1Data,
   input  logic                 m1Lock,
   output logic                 m1Ack,
   output logic                 m1RValid,
   output logic [7:0]           rData,
   input  logic                 tearFreeEn,
   input  logic                 neoState,
   output logic [ADDR_BITS-1:0] busAddr,
   output logic [7:0]           busDataIn,
   output logic                 busWrite,
   output logic                 busRead,
   input  logic [7:0]           busDataOut,
   output logic                 owner,
   output logic                 deferred
);

   localparam int unsigned HoldW = $clog2(HOLD_MAX + 1);

   typedef enum logic [2:0] {StIdle, StIssue, StRdWait, StRdRet, StDefer} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] neo_sync_q;
   logic                   neo_ready;

   logic                   owner_q, owner_d;
   logic                   last_grant_q, last_grant_d;
   logic                   lock_q, lock_d;
   logic [HoldW-1:0]       hold_q, hold_d;

   logic                   cmd_write_q, cmd_write_d;
   logic [ADDR_BITS-1:0]   cmd_addr_q, cmd_addr_d;
   logic [7:0]             cmd_data_q, cmd_data_d;

   logic [ADDR_BITS-1:0]   bus_addr_q, bus_addr_d;
   logic [7:0]             bus_data_q, bus_data_d;
   logic                   bus_write_q, bus_write_d;
   logic                   bus_read_q, bus_read_d;
   logic                   ack0_q, ack0_d, ack1_q, ack1_d;
   logic                   rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [7:0]             rdata_q, rdata_d;

   logic                   keep, hold_full, win, grant, issue_next;

   // neoState comes from the controller's own clock domain.
   always_ff @(posedge busClk or negedge busResetN) begin
      if (!busResetN) begin
         neo_sync_q <= '0;
      end else begin
         neo_sync_q <= {neo_sync_q[SYNC_STAGES-2:0], neoState};
      end
   end

   assign neo_ready = neo_sync_q[SYNC_STAGES-1];

   // A locking owner keeps the grant until it has had HOLD_MAX in a row and the
   // other master is waiting; unlocked ties go to the master not granted last.
   always_comb begin
      keep      = lock_q & (owner_q ? m1Req : m0Req);
      hold_full = (hold_q >= HoldW'(HOLD_MAX));
      win       = m1Req;
      if (m0Req && m1Req) begin
         if (keep && !hold_full) begin
            win = owner_q;
         end else if (keep) begin
            win = ~owner_q;
         end else begin
            win = ~last_grant_q;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant       = 1'b0;
      cmd_write_d = cmd_write_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_data_d  = cmd_data_q;
      lock_d      = lock_q;

      unique case (state_q)
         StIdle: begin
            if (m0Req || m1Req) begin
               grant       = 1'b1;
               cmd_write_d = win ? m1Write : m0Write;
               cmd_addr_d  = win ? m1Addr : m0Addr;
               cmd_data_d  = win ? m1Data : m0Data;
               lock_d      = win ? m1Lock : m0Lock;
               if (cmd_write_d && !cmd_addr_d[ADDR_BITS-1] && tearFreeEn && !neo_ready) begin
                  state_d = StDefer;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue:  state_d = cmd_write_q ? StIdle : StRdWait;
         StRdWait: state_d = StRdRet;
         StRdRet:  state_d = StIdle;
         StDefer: begin
            if (neo_ready || !tearFreeEn) begin
               state_d = StIssue;
            end
         end
         default:  state_d = StIdle;
      endcase
   end

   // holdCnt counts consecutive grants to the current owner; a change of owner
   // restarts the count at this first grant.
   always_comb begin
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      hold_d       = hold_q;
      if (grant) begin
         owner_d      = win;
         last_grant_d = win;
         if (win == owner_q) begin
            hold_d = hold_full ? hold_q : hold_q + HoldW'(1);
         end else begin
            hold_d = HoldW'(1);
         end
      end
   end

   // Bus outputs are registered from the next state so the strobe and the ack
   // appear together in the ISSUE cycle.
   always_comb begin
      issue_next  = (state_d == StIssue);
      bus_write_d = issue_next & cmd_write_d;
      bus_read_d  = issue_next & ~cmd_write_d;
      ack0_d      = issue_next & ~owner_d;
      ack1_d      = issue_next & owner_d;
      bus_addr_d  = issue_next ? cmd_addr_d : bus_addr_q;
      bus_data_d  = issue_next ? cmd_data_d : bus_data_q;
      rvalid0_d   = (state_q == StRdWait) & ~owner_q;
      rvalid1_d   = (state_q == StRdWait) & owner_q;
      rdata_d     = (state_q == StRdWait) ? busDataOut : rdata_q;
   end

   always_ff @(posedge busClk or negedge busResetN) begin
      if (!busResetN) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         lock_q       <= 1'b0;
         hold_q       <= '0;
         cmd_write_q  <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_data_q   <= '0;
         bus_addr_q   <= '0;
         bus_data_q   <= '0;
         bus_write_q  <= 1'b0;
         bus_read_q   <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         lock_q       <= lock_d;
         hold_q       <= hold_d;
         cmd_write_q  <= cmd_write_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_data_q   <= cmd_data_d;
         bus_addr_q   <= bus_addr_d;
         bus_data_q   <= bus_data_d;
         bus_write_q  <= bus_write_d;
         bus_read_q   <= bus_read_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         rdata_q      <= rdata_d;
      end
   end

   assign busAddr   = bus_addr_q;
   assign busDataIn = bus_data_q;
   assign busWrite  = bus_write_q;
   assign busRead   = bus_read_q;
   assign m0Ack     = ack0_q;
   assign m1Ack     = ack1_q;
   assign m0RValid  = rvalid0_q;
   assign m1RValid  = rvalid1_q;
   assign rData     = rdata_q;
   assign owner     = owner_q;
   assign deferred  = (state_q == StDefer);

endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// Directed bench for anton_neopixel_bus_arbiter: write, contention, lock bound,
// read return, tear-free deferral and asynchronous reset.
module tb_anton_neopixel_bus_arbiter;

   localparam int unsigned AW = 14;

   logic          busClk = 1'b0;
   logic          busResetN;
   logic          m0Req, m0Write, m0Lock, m1Req, m1Write, m1Lock;
   logic [AW-1:0] m0Addr, m1Addr;
   logic [7:0]    m0Data, m1Data;
   logic          m0Ack, m1Ack, m0RValid, m1RValid;
   logic [7:0]    rData;
   logic          tearFreeEn, neoState;
   logic [AW-1:0] busAddr;
   logic [7:0]    busDataIn, busDataOut;
   logic          busWrite, busRead, owner, deferred;

   int n_vec  = 0;
   int n_miss = 0;

   anton_neopixel_bus_arbiter #(
      .ADDR_BITS  (AW),
      .HOLD_MAX   (4),
      .SYNC_STAGES(2)
   ) dut (
      .busClk    (busClk),
      .busResetN (busResetN),
      .m0Req     (m0Req),
      .m0Write   (m0Write),
      .m0Addr    (m0Addr),
      .m0Data    (m0Data),
      .m0Lock    (m0Lock),
      .m0Ack     (m0Ack),
      .m0RValid  (m0RValid),
      .m1Req     (m1Req),
      .m1Write   (m1Write),
      .m1Addr    (m1Addr),
      .m1Data    (m1Data),
      .m1Lock    (m1Lock),
      .m1Ack     (m1Ack),
      .m1RValid  (m1RValid),
      .rData     (rData),
      .tearFreeEn(tearFreeEn),
      .neoState  (neoState),
      .busAddr   (busAddr),
      .busDataIn (busDataIn),
      .busWrite  (busWrite),
      .busRead   (busRead),
      .busDataOut(busDataOut),
      .owner     (owner),
      .deferred  (deferred)
   );

   always #5 busClk = ~busClk;

   // Controller model: read data is valid only in the cycle after the strobe.
   always @(posedge busClk) busDataOut <= busRead ? 8'h01 : 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge busClk);
      #1;
   endtask

   task automatic do_reset();
      busResetN = 1'b0;
      m0Req = 0; m1Req = 0; m0Lock = 0; m1Lock = 0;
      m0Write = 0; m1Write = 0; m0Addr = '0; m1Addr = '0; m0Data = '0; m1Data = '0;
      step();
      step();
      busResetN = 1'b1;
   endtask

   initial begin
      tearFreeEn = 1'b0;
      neoState   = 1'b0;
      do_reset();

      chk("rst_strobes", {busWrite, busRead, m0Ack, m1Ack, m0RValid, m1RValid, deferred}, 0);
      chk("rst_bus", {busAddr, busDataIn, rData}, 0);
      chk("rst_owner", owner, 0);

      // Single write
      m0Req = 1; m0Write = 1; m0Addr = 14'h0005; m0Data = 8'hA5;
      step();
      chk("wr_strobe", {busWrite, busRead}, 2'b10);
      chk("wr_addr", busAddr, 14'h0005);
      chk("wr_data", busDataIn, 8'hA5);
      chk("wr_ack", {m1Ack, m0Ack}, 2'b01);
      chk("wr_owner", owner, 0);
      m0Req = 0;
      step();
      chk("wr_strobe_end", {busWrite, m0Ack}, 0);
      chk("wr_addr_hold", {busAddr, busDataIn}, {14'h0005, 8'hA5});

      // Contention, no lock: m0, m1, m0, m1 with acks 2 cycles apart
      do_reset();
      m0Req = 1; m0Write = 1; m0Addr = 14'h0010; m0Data = 8'h10;
      m1Req = 1; m1Write = 1; m1Addr = 14'h0011; m1Data = 8'h11;
      for (int k = 1; k <= 8; k++) begin
         step();
         case (k)
            1, 5:    chk("rr_ack", {m1Ack, m0Ack}, 2'b01);
            3, 7:    chk("rr_ack", {m1Ack, m0Ack}, 2'b10);
            default: chk("rr_gap", {m1Ack, m0Ack}, 2'b00);
         endcase
      end
      chk("rr_owner", owner, 1);

      // Lock starvation bound with HOLD_MAX = 4
      do_reset();
      begin
         logic exp_g [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
         m0Req = 1; m0Write = 1; m0Addr = 14'h0020; m0Data = 8'h20;
         m1Req = 1; m1Write = 1; m1Addr = 14'h0021; m1Data = 8'h21; m1Lock = 1;
         for (int g = 0; g < 11; g++) begin
            step();
            chk("lock_ack", {m1Ack, m0Ack}, exp_g[g] ? 2'b10 : 2'b01);
            step();
            chk("lock_gap", {m1Ack, m0Ack}, 2'b00);
         end
         m0Req = 0; m1Req = 0; m1Lock = 0;
      end

      // Read path
      do_reset();
      m1Req = 1; m1Write = 0; m1Addr = 14'h2003;
      step();
      chk("rd_strobe", {busRead, busWrite}, 2'b10);
      chk("rd_addr", busAddr, 14'h2003);
      chk("rd_ack", {m1Ack, m0Ack}, 2'b10);
      m1Req = 0;
      step();
      chk("rd_wait", {busRead, m1RValid, m0RValid}, 0);
      step();
      chk("rd_valid", {m1RValid, m0RValid}, 2'b10);
      chk("rd_data", rData, 8'h01);
      chk("rd_owner", owner, 1);
      step();
      chk("rd_valid_end", {m1RValid, m0RValid}, 0);
      chk("rd_data_hold", rData, 8'h01);

      // Tear-free deferral of a pixel-buffer write
      do_reset();
      tearFreeEn = 1; neoState = 0;
      m0Req = 1; m0Write = 1; m0Addr = 14'h0002; m0Data = 8'h3C;
      begin
         int bad = 0;
         for (int c = 0; c < 50; c++) begin
            step();
            if (busWrite !== 1'b0 || deferred !== 1'b1 || m0Ack !== 1'b0) bad++;
         end
         chk("tf_held_cycles_bad", bad, 0);
      end
      neoState = 1;
      step();
      chk("tf_sync1", {busWrite, deferred}, 2'b01);
      step();
      chk("tf_sync2", {busWrite, deferred}, 2'b01);
      step();
      chk("tf_release", {busWrite, deferred, m0Ack}, 3'b101);
      chk("tf_addr", {busAddr, busDataIn}, {14'h0002, 8'h3C});
      m0Req = 0; neoState = 0;
      step(); step(); step();
      m0Req = 1; m0Addr = 14'h2002; m0Data = 8'h77;
      step();
      chk("tf_reg_now", {busWrite, deferred, m0Ack}, 3'b101);
      chk("tf_reg_addr", busAddr, 14'h2002);
      m0Req = 0; tearFreeEn = 0;
      step();

      // Reset mid-read: outputs clear asynchronously, no RValid afterwards
      do_reset();
      m1Req = 1; m1Write = 0; m1Addr = 14'h2005;
      step();
      m1Req = 0;
      step();
      busResetN = 0;
      #1;
      chk("rst_async_strobes", {busWrite, busRead, m0Ack, m1Ack, m0RValid, m1RValid, deferred}, 0);
      chk("rst_async_bus", {busAddr, busDataIn, rData, owner}, 0);
      step();
      chk("rst_no_rvalid", {m0RValid, m1RValid}, 0);
      busResetN = 1;
      step();
      chk("rst_no_rvalid_after", {m0RValid, m1RValid}, 0);
      m0Req = 1; m0Write = 1; m0Addr = 14'h0001;
      m1Req = 1; m1Write = 1; m1Addr = 14'h0002;
      step();
      chk("rst_first_tie", {m1Ack, m0Ack}, 2'b01);
      m0Req = 0;
      step();

      // Reset while a strobe is on the bus: it drops with no ack
      do_reset();
      m0Req = 1; m0Write = 1; m0Addr = 14'h2010; m0Data = 8'h5A;
      step();
      chk("rst_inflight_pre", {busWrite, m0Ack}, 2'b11);
      busResetN = 0;
      #1;
      chk("rst_inflight_drop", {busWrite, m0Ack}, 0);
      m0Req = 0;
      step();
      busResetN = 1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
